// File: rtl/exec_result_queue_pkg.sv
// Shared types for the per-lane execute result queues.
// exec_result_t is the payload that travels from a unit to the execute-output arbiter.
package exec_pkg;
  localparam int EXEC_LANES   = 4;
  localparam int CMD_W        = 10;
  localparam int FLAG_W       = 4;
  localparam int ROB_SIZE     = 32;
  localparam int ROB_SIZE_LOG = $clog2(ROB_SIZE + 1);

  typedef struct packed {
    logic [63:0]             val;
    logic [CMD_W-1:0]        cmd;
    logic [ROB_SIZE_LOG-1:0] tag;
    logic [FLAG_W-1:0]       flags;
  } exec_result_t;
endpackage

// File: rtl/exec_result_mem.sv
// DEPTH-entry result storage: one synchronous write port, one combinational read port.
// Contents are never cleared; the owner gates visibility with its own occupancy.
module exec_result_mem
  import exec_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         clk_i,
  input  logic         we_i,
  input  logic [AW-1:0] waddr_i,
  input  exec_result_t wdata_i,
  input  logic [AW-1:0] raddr_i,
  output exec_result_t rdata_o
);

  exec_result_t mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/exec_result_queue.sv
// Per-unit in-order result buffer feeding the execute-output arbiter; push-to-head latency 1 cycle.
// ready_o depends only on occupancy, so a full queue stalls the unit even when the head is granted.
module exec_result_queue
  import exec_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int ROBsize    = ROB_SIZE,
  parameter int ROBsizeLog = $clog2(ROBsize + 1)
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       flush_i,
  input  logic [63:0]                unitVal_i,
  input  logic [CMD_W-1:0]           unitCmd_i,
  input  logic [ROBsizeLog-1:0]      unitTag_i,
  input  logic [FLAG_W-1:0]          unitFlags_i,
  input  logic                       unitValid_i,
  output logic                       ready_o,
  input  logic                       grant_i,
  output logic                       valid_o,
  output logic [63:0]                val_o,
  output logic [CMD_W-1:0]           cmd_o,
  output logic [ROBsizeLog-1:0]      tag_o,
  output logic [FLAG_W-1:0]          flags_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;
  exec_result_t  wr_res, head_res;

  assign ready_o = (count_q < FULL_CNT);
  assign valid_o = (count_q != '0);
  assign push    = unitValid_i & ready_o;
  assign pop     = grant_i & valid_o;

  assign wr_res.val   = unitVal_i;
  assign wr_res.cmd   = unitCmd_i;
  assign wr_res.tag   = unitTag_i;
  assign wr_res.flags = unitFlags_i;

  // A push squashed by flush/reset must not land; skipping the write keeps storage tidy too.
  exec_result_mem #(.DEPTH(DEPTH)) u_mem (
    .clk_i   (clk_i),
    .we_i    (push & ~flush_i & ~reset_i),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_res),
    .raddr_i (rd_ptr_q),
    .rdata_o (head_res)
  );

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign val_o   = valid_o ? head_res.val   : '0;
  assign cmd_o   = valid_o ? head_res.cmd   : '0;
  assign tag_o   = valid_o ? head_res.tag   : '0;
  assign flags_o = valid_o ? head_res.flags : '0;
  assign count_o = count_q;

endmodule

// File: tb/tb_exec_result_queue.sv
// Randomized and directed bench for exec_result_queue against a queue-based reference model.
module tb_exec_result_queue;
  import exec_pkg::*;

  localparam int DEPTH = 4;
  localparam int TW    = ROB_SIZE_LOG;
  localparam int CW    = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              reset_i, flush_i, unitValid_i, grant_i;
  logic [63:0]       unitVal_i;
  logic [CMD_W-1:0]  unitCmd_i;
  logic [TW-1:0]     unitTag_i;
  logic [FLAG_W-1:0] unitFlags_i;
  logic              ready_o, valid_o;
  logic [63:0]       val_o;
  logic [CMD_W-1:0]  cmd_o;
  logic [TW-1:0]     tag_o;
  logic [FLAG_W-1:0] flags_o;
  logic [CW-1:0]     count_o;

  exec_result_t mq[$];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  exec_result_queue #(.DEPTH(DEPTH)) dut (
    .clk_i(clk), .reset_i(reset_i), .flush_i(flush_i),
    .unitVal_i(unitVal_i), .unitCmd_i(unitCmd_i), .unitTag_i(unitTag_i),
    .unitFlags_i(unitFlags_i), .unitValid_i(unitValid_i), .ready_o(ready_o),
    .grant_i(grant_i), .valid_o(valid_o), .val_o(val_o), .cmd_o(cmd_o),
    .tag_o(tag_o), .flags_o(flags_o), .count_o(count_o)
  );

  function automatic exec_result_t exp_head();
    exec_result_t r;
    r = '0;
    if (mq.size() > 0) r = mq[0];
    return r;
  endfunction

  // Sets a unit result with random payload around the given tag.
  task automatic drive(input logic v, input int tag);
    unitValid_i = v;
    unitTag_i   = TW'(tag);
    unitVal_i   = {$urandom, $urandom};
    unitCmd_i   = CMD_W'($urandom);
    unitFlags_i = FLAG_W'($urandom);
  endtask

  // Advances one clock and updates the model from the inputs seen at that edge.
  task automatic tick();
    bit mpush, mpop;
    exec_result_t r;
    mpush = unitValid_i && (mq.size() < DEPTH);
    mpop  = grant_i && (mq.size() > 0);
    r.val = unitVal_i; r.cmd = unitCmd_i; r.tag = unitTag_i; r.flags = unitFlags_i;
    @(posedge clk);
    if (reset_i || flush_i) mq.delete();
    else begin
      if (mpop)  void'(mq.pop_front());
      if (mpush) mq.push_back(r);
    end
    #1;
  endtask

  task automatic do_reset();
    reset_i = 1'b1; flush_i = 1'b0; grant_i = 1'b0; drive(1'b0, 0);
    tick();
    reset_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({valid_o, ready_o, count_o} !== {1'b0, 1'b1, CW'(0)}) begin
      n_fail++; $display("FAIL reset_flags: valid=%0b ready=%0b count=%0d, want 0 1 0", valid_o, ready_o, count_o);
    end
    n_tests++;
    if ({val_o, cmd_o, tag_o, flags_o} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: val=%h tag=%0d, want all zero", val_o, tag_o);
    end
  endtask

  task automatic test_partial_fill();
    do_reset();
    for (int t = 1; t <= 3; t++) begin drive(1'b1, t); tick(); end
    drive(1'b0, 0);
    n_tests++;
    if ({count_o, valid_o, tag_o, ready_o} !== {CW'(3), 1'b1, TW'(1), 1'b1}) begin
      n_fail++; $display("FAIL partial_fill: count=%0d valid=%0b tag=%0d ready=%0b, want 3 1 1 1", count_o, valid_o, tag_o, ready_o);
    end
    n_tests++;
    if ({val_o, cmd_o, tag_o, flags_o} !== exp_head()) begin
      n_fail++; $display("FAIL partial_head: got %h want %h", {val_o, cmd_o, tag_o, flags_o}, exp_head());
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int t = 10; t < 14; t++) begin drive(1'b1, t); tick(); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 9);
      n_tests++;
      if ({ready_o, count_o} !== {1'b0, CW'(4)}) begin
        n_fail++; $display("FAIL full_hold: ready=%0b count=%0d, want 0 4", ready_o, count_o);
      end
      tick();
    end
    // A pop while full must still refuse the held push.
    grant_i = 1'b1;
    tick();
    drive(1'b0, 0);
    for (int t = 11; t < 14; t++) begin
      n_tests++;
      if (tag_o !== TW'(t)) begin
        n_fail++; $display("FAIL full_drain: tag=%0d want %0d", tag_o, t);
      end
      tick();
    end
    grant_i = 1'b0;
    n_tests++;
    if ({valid_o, count_o} !== {1'b0, CW'(0)}) begin
      n_fail++; $display("FAIL full_no_tag9: valid=%0b count=%0d tag=%0d, want empty", valid_o, count_o, tag_o);
    end
  endtask

  task automatic test_simul_push_pop();
    do_reset();
    drive(1'b1, 5); tick();
    drive(1'b1, 6); tick();
    drive(1'b1, 7); grant_i = 1'b1; tick();
    drive(1'b0, 0); grant_i = 1'b0;
    n_tests++;
    if ({tag_o, count_o} !== {TW'(6), CW'(2)}) begin
      n_fail++; $display("FAIL simul_push_pop: tag=%0d count=%0d, want 6 2", tag_o, count_o);
    end
  endtask

  task automatic test_stream_wrap();
    int got[$];
    int sent = 0;
    bit acc;
    do_reset();
    for (int cyc = 0; cyc < 100 && sent < 10; cyc++) begin
      drive(1'b1, sent);
      grant_i = cyc[0];
      if (grant_i && valid_o) got.push_back(int'(tag_o));
      acc = ready_o;
      tick();
      if (acc) sent++;
    end
    drive(1'b0, 0);
    grant_i = 1'b1;
    for (int cyc = 0; cyc < 20 && valid_o; cyc++) begin
      got.push_back(int'(tag_o));
      tick();
    end
    grant_i = 1'b0;
    n_tests++;
    if (got.size() != 10) begin
      n_fail++; $display("FAIL stream_count: got %0d results, want 10", got.size());
    end
    for (int i = 0; i < got.size() && i < 10; i++) begin
      n_tests++;
      if (got[i] != i) begin
        n_fail++; $display("FAIL stream_order[%0d]: tag=%0d want %0d", i, got[i], i);
      end
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int t = 1; t <= 3; t++) begin drive(1'b1, t); tick(); end
    drive(1'b1, 20); flush_i = 1'b1; tick();
    flush_i = 1'b0; drive(1'b0, 0);
    n_tests++;
    if ({count_o, valid_o, ready_o} !== {CW'(0), 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL flush_state: count=%0d valid=%0b ready=%0b, want 0 0 1", count_o, valid_o, ready_o);
    end
    n_tests++;
    if ({val_o, cmd_o, tag_o, flags_o} !== '0) begin
      n_fail++; $display("FAIL flush_outputs: tag=%0d val=%h, want zero", tag_o, val_o);
    end
    drive(1'b1, 21); tick(); drive(1'b0, 0);
    n_tests++;
    if ({tag_o, count_o} !== {TW'(21), CW'(1)}) begin
      n_fail++; $display("FAIL flush_after_push: tag=%0d count=%0d, want 21 1", tag_o, count_o);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(1'b1, 1); tick();
    drive(1'b1, 2); tick();
    drive(1'b0, 0); grant_i = 1'b1; reset_i = 1'b1; tick();
    reset_i = 1'b0; grant_i = 1'b0;
    n_tests++;
    if ({valid_o, ready_o, count_o} !== {1'b0, 1'b1, CW'(0)}) begin
      n_fail++; $display("FAIL reset_mid: valid=%0b ready=%0b count=%0d, want 0 1 0", valid_o, ready_o, count_o);
    end
    drive(1'b1, 4); tick(); drive(1'b0, 0);
    n_tests++;
    if ({valid_o, tag_o} !== {1'b1, TW'(4)}) begin
      n_fail++; $display("FAIL reset_mid_push: valid=%0b tag=%0d, want 1 4", valid_o, tag_o);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      drive(($urandom_range(0, 3) != 0), int'($urandom_range(0, 31)));
      grant_i = ($urandom_range(0, 2) == 0);
      flush_i = ($urandom_range(0, 40) == 0);
      tick();
      n_tests++;
      if ({valid_o, ready_o, count_o} !== {mq.size() > 0, mq.size() < DEPTH, CW'(mq.size())}) begin
        n_fail++; $display("FAIL random_state@%0d: valid=%0b ready=%0b count=%0d, model size %0d", cyc, valid_o, ready_o, count_o, mq.size());
      end
      n_tests++;
      if ({val_o, cmd_o, tag_o, flags_o} !== exp_head()) begin
        n_fail++; $display("FAIL random_head@%0d: got %h want %h", cyc, {val_o, cmd_o, tag_o, flags_o}, exp_head());
      end
    end
    flush_i = 1'b0; grant_i = 1'b0; drive(1'b0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_partial_fill();
    test_full();
    test_simul_push_pop();
    test_stream_wrap();
    test_flush();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
